mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter PORT_LEN, default 16, memory data/mask width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from mem_read_o to valid mem_data_i; legal range 1..7.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports reqN_i (N=0,1)  input  1  requester N transaction request, level.
REQ-007 SHALL have ports writeN_i  input  1  requester N: 1 = write, 0 = read.
REQ-008 SHALL have ports addrN_i  input  XLEN  requester N byte address.
REQ-009 SHALL have ports dataN_i / maskN_i  input  PORT_LEN  requester N write data / write mask.
REQ-010 SHALL have ports ackN_o  output  1  one-cycle completion pulse to requester N.
REQ-011 SHALL have ports dataN_o  output  PORT_LEN  read data to requester N, valid with ackN_o.
REQ-012 SHALL have ports mem_read_o / mem_write_o  output  1  shared memory port strobes.
REQ-013 SHALL have ports mem_addr_o  output  XLEN; mem_data_o / mem_mask_o  output  PORT_LEN; all registered.
REQ-014 SHALL have port mem_data_i  input  PORT_LEN  shared memory read data.
REQ-015 SHALL have ports busy_o  output  1  state != IDLE; grant_o  output  1  index of current/last owner.

Function
REQ-016 SHALL implement states IDLE, ACCESS, WAIT, ACK.
REQ-017 IDLE: if any reqN_i high, select winner, latch its write/addr/data/mask into mem_* registers, set grant_o, go ACCESS next cycle; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin: only one requesting -> it wins; both requesting -> the one not equal to last_grant wins.
REQ-019 ACCESS: mem_read_o or mem_write_o SHALL be high for exactly this one cycle, never both.
REQ-020 ACCESS write -> ACK; ACCESS read -> WAIT with counter loaded to READ_LATENCY-1.
REQ-021 WAIT: decrement counter each cycle; at count 0, capture mem_data_i into dataN_o of the granted requester and go ACK.
REQ-022 ACK: ackN_o high one cycle for granted requester only; last_grant <= grant_o; go IDLE.
REQ-023 Latency: write ack 3 cycles after IDLE acceptance edge; read ack 3+READ_LATENCY cycles after it.
REQ-024 Request fields SHALL be sampled only in IDLE; changes or req deassertion during a transaction SHALL be ignored and the transaction completed.
REQ-025 A req held high through ACK SHALL be re-arbitrated in the following IDLE as a new transaction.
REQ-026 dataN_o SHALL update only on a read completing for requester N; held otherwise.
REQ-027 mem_addr_o/mem_data_o/mem_mask_o SHALL hold their last values outside ACCESS/WAIT.

Reset
REQ-028 reset_i high SHALL asynchronously force state IDLE, all strobes, acks, busy_o, counter, mem_*, dataN_o to 0, grant_o 0, last_grant 1.
REQ-029 Reset mid-transaction SHALL abort it with no ack and no further memory strobe.

Structure
REQ-030 State encoding and READ_LATENCY bounds SHALL live in a shared package with the other rv32i constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_select2 (inputs req[1:0], last; output winner, valid); no other sub-modules.

Verification
REQ-032 Single write: req0, addr 0x00010004, data 0xBEEF, mask 0xFFFF -> one mem_write_o cycle with those values, ack0_o 3 cycles later, ack1_o never.
REQ-033 Single read, READ_LATENCY=2: req1, addr 0x00020000, mem_data_i 0x1234 at latency -> data1_o=0x1234 with ack1_o at cycle 5.
REQ-034 Both req held continuously from reset -> grants 0,1,0,1; no two consecutive acks to same requester.
REQ-035 req0 dropped and addr0_i changed during WAIT -> transaction completes with original address, ack0_o still pulses.
REQ-036 reset_i asserted in WAIT -> immediate IDLE, no ack, busy_o 0; next req1 served normally.
REQ-037 READ_LATENCY=1 and 7 builds: read ack at cycles 4 and 10 respectively.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter and the rest of the rv32i slice.
// Holds the FSM encoding and the legal read-latency window.
package mem_arbiter_pkg;

    localparam int RV_XLEN     = 32;
    localparam int RV_PORT_LEN = 16;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 7;
    localparam int CNT_W            = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    // Out-of-range latencies are pinned to the window so the counter can never wrap.
    function automatic logic [CNT_W-1:0] wait_load(input int lat);
        int l;
        l = (lat < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
            (lat > READ_LATENCY_MAX) ? READ_LATENCY_MAX : lat;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// slave is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN     = RV_XLEN,
    parameter int PORT_LEN = RV_PORT_LEN
) ();

    logic                req0_i,   req1_i;
    logic                write0_i, write1_i;
    logic [XLEN-1:0]     addr0_i,  addr1_i;
    logic [PORT_LEN-1:0] data0_i,  data1_i;
    logic [PORT_LEN-1:0] mask0_i,  mask1_i;
    logic                ack0_o,   ack1_o;
    logic [PORT_LEN-1:0] data0_o,  data1_o;
    logic                mem_read_o, mem_write_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [PORT_LEN-1:0] mem_data_o, mem_mask_o;
    logic [PORT_LEN-1:0] mem_data_i;
    logic                busy_o, grant_o;

    modport slave (
        input  req0_i, req1_i, write0_i, write1_i, addr0_i, addr1_i,
               data0_i, data1_i, mask0_i, mask1_i, mem_data_i,
        output ack0_o, ack1_o, data0_o, data1_o, mem_read_o, mem_write_o,
               mem_addr_o, mem_data_o, mem_mask_o, busy_o, grant_o
    );

    modport master (
        output req0_i, req1_i, write0_i, write1_i, addr0_i, addr1_i,
               data0_i, data1_i, mask0_i, mask1_i, mem_data_i,
        input  ack0_o, ack1_o, data0_o, data1_o, mem_read_o, mem_write_o,
               mem_addr_o, mem_data_o, mem_mask_o, busy_o, grant_o
    );

endinterface

// File: rtl/mem_arbiter_rr_select2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the one not served last wins.
module rr_select2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    assign valid  = |req;
    assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single registered memory port.
//   state     | meaning
//   ST_IDLE   | sample requests, latch winner's fields into mem_* registers
//   ST_ACCESS | single-cycle read or write strobe
//   ST_WAIT   | count down read latency, capture mem_data_i at zero
//   ST_ACK    | register the one-cycle ack to the owner, record last grant
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN         = RV_XLEN,
    parameter int PORT_LEN     = RV_PORT_LEN,
    parameter int READ_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] L_WAIT_LOAD = wait_load(READ_LATENCY);

    state_t              r_state;
    logic                r_grant, r_last, r_is_write;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_read, r_mem_write;
    logic [XLEN-1:0]     r_mem_addr;
    logic [PORT_LEN-1:0] r_mem_data, r_mem_mask;
    logic [PORT_LEN-1:0] r_data0, r_data1;
    logic                r_ack0, r_ack1;

    logic                w_winner, w_valid;
    logic                w_sel_write;
    logic [XLEN-1:0]     w_sel_addr;
    logic [PORT_LEN-1:0] w_sel_data, w_sel_mask;

    rr_select2 u_rr (
        .req    ({bus.req1_i, bus.req0_i}),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_sel_write = w_winner ? bus.write1_i : bus.write0_i;
    assign w_sel_addr  = w_winner ? bus.addr1_i  : bus.addr0_i;
    assign w_sel_data  = w_winner ? bus.data1_i  : bus.data0_i;
    assign w_sel_mask  = w_winner ? bus.mask1_i  : bus.mask0_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_last      <= 1'b1;
            r_is_write  <= 1'b0;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_mask  <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_winner;
                        r_is_write  <= w_sel_write;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_data  <= w_sel_data;
                        r_mem_mask  <= w_sel_mask;
                        r_mem_write <= w_sel_write;
                        r_mem_read  <= ~w_sel_write;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_is_write) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= L_WAIT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_grant) r_data1 <= bus.mem_data_i;
                        else         r_data0 <= bus.mem_data_i;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_ack0  <= ~r_grant;
                    r_ack1  <= r_grant;
                    r_last  <= r_grant;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0_o      = r_ack0;
    assign bus.ack1_o      = r_ack1;
    assign bus.data0_o     = r_data0;
    assign bus.data1_o     = r_data1;
    assign bus.mem_read_o  = r_mem_read;
    assign bus.mem_write_o = r_mem_write;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_data_o  = r_mem_data;
    assign bus.mem_mask_o  = r_mem_mask;
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.grant_o     = r_grant;

endmodule
